// File: rtl/enc_prio_n_reg.sv
// Registered N-to-log2(N) priority encoder with valid/ready handshakes, a 1-deep output
// register and a saturating multi-hot counter. Define ENC_ROUND_ROBIN_EN for round-robin priority.
module enc_prio_n_reg #(
  parameter int N            = 8,
  parameter bit LOWEST_FIRST = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_n,
  input  logic [N-1:0]             req,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(N)-1:0]     y,
  output logic                     zero,
  output logic                     multi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         multi_cnt
);

  localparam int W = $clog2(N);
  localparam logic [N-1:0]     REQ_ONE = N'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic         accept;
  logic         req_zero;
  logic         req_multi;
  logic [W-1:0] grant;

  assign out_valid = (state_q == FULL);
  // A FULL entry can be replaced in the same cycle it drains, giving full throughput.
  assign in_ready  = !en_n && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign req_zero  = (req == '0);
  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign req_multi = |(req & (req - REQ_ONE));

`ifdef ENC_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr;

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    int  idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant = idx[W-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && !req_zero) begin
      rr_ptr <= (grant == W'(N - 1)) ? '0 : grant + W'(1);
    end
  end
`else
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = LOWEST_FIRST ? i : (N - 1 - i);
      if (!found && req[idx]) begin
        grant = idx[W-1:0];
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y         <= '0;
      zero      <= 1'b0;
      multi     <= 1'b0;
      multi_cnt <= '0;
    end else if (accept) begin
      y     <= grant;
      zero  <= req_zero;
      multi <= req_multi;
      if (req_multi && (multi_cnt != CNT_MAX)) begin
        multi_cnt <= multi_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enc_prio_n_reg.sv
// Self-checking bench for enc_prio_n_reg: directed vector table, hand sequences for
// saturation / async reset / priority order, and randomized traffic against a transaction model.
module tb_enc_prio_n_reg;

  localparam int N     = 8;
  localparam int W     = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en_n;
  logic [N-1:0]     req;
  logic             in_valid;
  logic             out_ready;
  logic             in_ready, in_ready_hi;
  logic [W-1:0]     y, y_hi;
  logic             zero, zero_hi;
  logic             multi, multi_hi;
  logic             out_valid, out_valid_hi;
  logic [CNT_W-1:0] multi_cnt, multi_cnt_hi;

  int errors = 0;
  int checks = 0;

  enc_prio_n_reg #(.N(N), .LOWEST_FIRST(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .req(req), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .zero(zero), .multi(multi), .out_valid(out_valid),
    .out_ready(out_ready), .multi_cnt(multi_cnt)
  );

  enc_prio_n_reg #(.N(N), .LOWEST_FIRST(1'b0), .CNT_W(CNT_W)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .req(req), .in_valid(in_valid),
    .in_ready(in_ready_hi), .y(y_hi), .zero(zero_hi), .multi(multi_hi), .out_valid(out_valid_hi),
    .out_ready(out_ready), .multi_cnt(multi_cnt_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [W-1:0] y_lo;
    logic [W-1:0] y_hi;
    logic         zero;
    logic         multi;
  } out_t;

  out_t exp_q[$];
  int   m_cnt;
  int   m_ptr;

  function automatic int prio(input logic [N-1:0] r, input int ptr, input bit lowest);
`ifdef ENC_ROUND_ROBIN_EN
    for (int off = 0; off < N; off++) if (r[(ptr + off) % N]) return (ptr + off) % N;
`else
    if (lowest) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_cnt = 0;
    m_ptr = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, exp_q.size() != 0);
    check("out_valid_hi", out_valid_hi, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("y", y, exp_q[0].y_lo);
      check("y_hi", y_hi, exp_q[0].y_hi);
      check("zero", zero, exp_q[0].zero);
      check("multi", multi, exp_q[0].multi);
    end
    check("multi_cnt", multi_cnt, m_cnt);
  endtask

  // Called at a negedge: drives one cycle of stimulus and checks against the model.
  task automatic model_cycle(input logic e, input logic [N-1:0] r, input logic iv, input logic o);
    bit   exp_rdy, acc;
    out_t rec;
    en_n = e; req = r; in_valid = iv; out_ready = o;
    #1;
    exp_rdy = !e && (exp_q.size() == 0 || o);
    check("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy;
    @(posedge clk);
    if (exp_q.size() != 0 && o) void'(exp_q.pop_front());
    if (acc) begin
      rec.y_lo  = W'(prio(r, m_ptr, 1'b1));
      rec.y_hi  = W'(prio(r, m_ptr, 1'b0));
      rec.zero  = (r == '0);
      rec.multi = ($countones(r) > 1);
      exp_q.push_back(rec);
      if (rec.multi && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`ifdef ENC_ROUND_ROBIN_EN
      if (r != '0) m_ptr = (int'(rec.y_lo) + 1) % N;
`endif
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en_n = 1'b0; req = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         en_n;
    logic [N-1:0] req;
    logic         in_valid;
    logic         out_ready;
    logic         exp_rdy;
    logic         exp_valid;
    logic [W-1:0] exp_y;
    logic [W-1:0] exp_y_hi;
    logic         exp_zero;
    logic         exp_multi;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [N-1:0] r;
    logic [W-1:0] rr_exp[5];

    vecs[0]  = '{1'b0, 8'h28, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 3'd5, 1'b0, 1'b1, 8'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 8'd1};
    vecs[2]  = '{1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 8'd1};
    vecs[3]  = '{1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 8'd1};
    vecs[4]  = '{1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 3'd7, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'd1};
    vecs[8]  = '{1'b0, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 8'd2};
    vecs[9]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 8'd2};

    rst_n = 1'b0; en_n = 1'b0; req = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, '0);
    check("rst_zero", zero, 1'b0);
    check("rst_multi", multi, 1'b0);
    check("rst_multi_cnt", multi_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

`ifndef ENC_ROUND_ROBIN_EN
    for (int i = 0; i < 11; i++) begin
      en_n = vecs[i].en_n; req = vecs[i].req;
      in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
        check($sformatf("vec%0d_y_hi", i), y_hi, vecs[i].exp_y_hi);
        check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
        check($sformatf("vec%0d_multi", i), multi, vecs[i].exp_multi);
      end
      check($sformatf("vec%0d_multi_cnt", i), multi_cnt, vecs[i].exp_cnt);
    end
`endif

    // Priority order under a constant request.
    do_reset();
`ifdef ENC_ROUND_ROBIN_EN
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd2; rr_exp[2] = 3'd7; rr_exp[3] = 3'd0; rr_exp[4] = 3'd2;
`else
    for (int i = 0; i < 5; i++) rr_exp[i] = 3'd0;
`endif
    for (int i = 0; i < 5; i++) begin
      en_n = 1'b0; req = 8'b1000_0101; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("order%0d_y", i), y, rr_exp[i]);
`ifdef ENC_ROUND_ROBIN_EN
      check($sformatf("order%0d_y_hi", i), y_hi, rr_exp[i]);
`else
      check($sformatf("order%0d_y_hi", i), y_hi, 3'd7);
`endif
    end

    // Saturation of the multi-hot counter, then async reset mid-stream.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      do r = N'($urandom); while ($countones(r) < 2);
      model_cycle(1'b0, r, 1'b1, 1'b1);
    end
    check("sat_multi_cnt", multi_cnt, 8'd255);
    check("sat_out_valid", out_valid, 1'b1);
    req = 8'hC3; in_valid = 1'b1; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_multi_cnt", multi_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized traffic with enable toggling and backpressure.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0:       r = '0;
        1:       r = N'(1) << $urandom_range(N - 1);
        default: r = N'($urandom);
      endcase
      model_cycle(($urandom_range(3) == 0), r, 1'($urandom_range(1)), ($urandom_range(3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
